mdu: RTL and testbench

- Multiply/divide unit in the EX stage, next to the ALU. It consumes the same forwarded rs/rt operands (A, B) as the ALU.
- Holds the architectural HI/LO registers. Executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes.
- The hazard unit uses start|busy to stall mfhi/mflo and further MDU instructions in ID.

---
 rtl/mdu.sv | 179 +++++++++++++++++
 tb/tb_mdu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns the architectural HI/LO registers and
// runs mult/multu/div/divu as fixed-latency operations; mthi/mtlo write in one cycle.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              busy_r, busy_s;
    logic [31:0]       hi_r, hi_s;
    logic [31:0]       lo_r, lo_s;
    logic [31:0]       sh_hi_r, sh_hi_s;
    logic [31:0]       sh_lo_r, sh_lo_s;
    logic [63:0]       result_s;

    // Returns {hi, lo} for a mult/div op; divide by zero and non-arithmetic ops return the current HI/LO.
    function automatic logic [63:0] calc_result(
        input logic [2:0]  f_op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] cur_hi,
        input logic [31:0] cur_lo
    );
        logic [63:0] r;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] rem;
        r     = {cur_hi, cur_lo};
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        q     = 32'd0;
        rem   = 32'd0;
        case (f_op)
            3'b000: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'b001: r = {32'd0, a} * {32'd0, b};
            3'b010: begin
                if (b != 32'd0) begin
                    // Magnitude divide, then fix signs: quotient truncates toward zero,
                    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
                    q   = mag_a / mag_b;
                    rem = mag_a % mag_b;
                    if (a[31] ^ b[31]) begin
                        q = 32'd0 - q;
                    end else begin
                        q = q;
                    end
                    if (a[31]) begin
                        rem = 32'd0 - rem;
                    end else begin
                        rem = rem;
                    end
                    r = {rem, q};
                end else begin
                    r = {cur_hi, cur_lo};
                end
            end
            3'b011: begin
                if (b != 32'd0) begin
                    r = {a % b, a / b};
                end else begin
                    r = {cur_hi, cur_lo};
                end
            end
            default: r = {cur_hi, cur_lo};
        endcase
        return r;
    endfunction

    // Result computed from the operands present at the issue edge.
    always_comb begin
        result_s = calc_result(op, A, B, hi_r, lo_r);
    end

    // Next-state and datapath update logic for the IDLE/RUN sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        sh_hi_s = sh_hi_r;
        sh_lo_s = sh_lo_r;
        case (state_r)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        3'b000, 3'b001: begin
                            sh_hi_s = result_s[63:32];
                            sh_lo_s = result_s[31:0];
                            cnt_s   = MULT_LOAD;
                            busy_s  = 1'b1;
                            state_s = RUN;
                        end
                        3'b010, 3'b011: begin
                            sh_hi_s = result_s[63:32];
                            sh_lo_s = result_s[31:0];
                            cnt_s   = DIV_LOAD;
                            busy_s  = 1'b1;
                            state_s = RUN;
                        end
                        3'b100:  hi_s = A;
                        3'b101:  lo_s = A;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == 4'd1) begin
                    hi_s    = sh_hi_r;
                    lo_s    = sh_lo_r;
                    busy_s  = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, HI/LO and shadow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            sh_hi_r <= 32'd0;
            sh_lo_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            sh_hi_r <= sh_hi_s;
            sh_lo_r <= sh_lo_s;
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length, a monitor
// checks them when busy drops; single-cycle effects are checked directly.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a_in),
        .B     (b_in),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic [31:0] o_hi, input logic [31:0] o_lo, input int cyc);
        exp_t e;
        e.hi = e_hi; e.lo = e_lo; e.old_hi = o_hi; e.old_lo = o_lo; e.cycles = cyc;
        sb_q.push_back(e);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: counts busy cycles, watches HI/LO hold, compares on completion.
    initial begin
        bit   was_busy = 1'b0;
        bit   stable = 1'b1;
        int   cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!was_busy) begin
                    cyc = 0;
                    stable = 1'b1;
                end
                cyc++;
                if (sb_q.size() > 0 && (hi !== sb_q[0].old_hi || lo !== sb_q[0].old_lo))
                    stable = 1'b0;
            end else if (was_busy) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("hi_result", hi, e.hi);
                    check("lo_result", lo, e.lo);
                    check("busy_cycles", cyc, e.cycles);
                    check("hilo_hold_during_busy", {31'd0, stable}, 32'd1);
                end
            end
            was_busy = (busy === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        push(32'hFFFFFFFF, 32'hFFFFFFFA, 32'd0, 32'd0, 5);
        do_op(3'b000, 32'hFFFFFFFE, 32'd3);
        wait_idle();

        push(32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000001, 10);
        do_op(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        push(32'h00000001, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        do_op(3'b011, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        push(32'h00000000, 32'h80000000, 32'h00000001, 32'h7FFFFFFC, 10);
        do_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        do_op(3'b100, 32'h00001234, 32'd0);
        check("mthi_hi", hi, 32'h00001234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        do_op(3'b101, 32'h00005678, 32'd0);
        check("mtlo_lo", lo, 32'h00005678);
        check("mtlo_hi_kept", hi, 32'h00001234);

        push(32'h00001234, 32'h00005678, 32'h00001234, 32'h00005678, 10);
        do_op(3'b011, 32'd100, 32'd0);
        wait_idle();

        // Flush raised during busy cycle 4 discards the divide.
        push(32'h00001234, 32'h00005678, 32'h00001234, 32'h00005678, 4);
        do_op(3'b010, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle();

        // Starts issued during RUN are ignored.
        push(32'h00000000, 32'h00000023, 32'h00001234, 32'h00005678, 5);
        do_op(3'b000, 32'd7, 32'd5);
        start = 1'b1; op = 3'b000; a_in = 32'd2; b_in = 32'd3;
        @(negedge clk);
        op = 3'b100; a_in = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
        wait_idle();
        repeat (3) @(negedge clk);
        check("run_start_ignored_busy", {31'd0, busy}, 32'd0);
        check("run_start_ignored_hi", hi, 32'd0);

        do_op(3'b110, 32'hAAAA5555, 32'd9);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", hi, 32'd0);
        check("nop_lo", lo, 32'h00000023);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b101; a_in = 32'h0000BEEF;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 3'b111;
        check("flush_beats_mtlo_lo", lo, 32'h00000023);
        check("flush_beats_mtlo_busy", {31'd0, busy}, 32'd0);

        // Reset in busy cycle 3 of a mult clears everything.
        push(32'd0, 32'd0, 32'd0, 32'h00000023, 3);
        do_op(3'b000, 32'd100, 32'd100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd0);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
